// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: MDU latency FSM and redirect-pending FSM.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_busy,
    input  logic       d_busy,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_redirect,
    input  logic       ex_mdu_start,
    output logic       pc_en,
    output logic       f2d_en,
    output logic       f2d_flush,
    output logic       d2e_en,
    output logic       d2e_flush,
    output logic       e2m_en,
    output logic       e2m_flush,
    output logic       m2w_en,
    output logic       m2w_flush,
    output logic       mdu_busy,
    output logic       redirect_pending
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_count
`endif
);

    if (MDU_LAT < 2 || MDU_LAT > 16 || CNT_W < 1) begin : g_bad_param
        $error("pipe_hazard_ctrl: illegal MDU_LAT or CNT_W");
    end

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } redir_state_e;

    localparam logic [4:0] CNT_INIT = 5'(MDU_LAT - 2);

    mdu_state_e   mdu_q, mdu_d;
    redir_state_e redir_q, redir_d;
    logic [4:0]   cnt_q, cnt_d;

    logic mdu_stall;
    logic load_use;
    logic redir_wait;
    logic redir_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_q   <= M_IDLE;
            redir_q <= R_IDLE;
            cnt_q   <= '0;
        end else begin
            mdu_q   <= mdu_d;
            redir_q <= redir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hazard classification; BUSY with cnt==0 is the cycle the result leaves EX.
    always_comb begin
        mdu_stall = (mdu_q == M_IDLE && ex_mdu_start)
                 || (mdu_q == M_BUSY && cnt_q != 5'd0);
        load_use  = ex_is_load && (ex_rd != 5'd0)
                 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        redir_wait   = (redir_q == R_WAIT);
        redir_accept = !redir_wait && ex_redirect && !d_busy && !mdu_stall;
    end

    always_comb begin
        pc_en     = 1'b1;
        f2d_en    = 1'b1;
        f2d_flush = 1'b0;
        d2e_en    = 1'b1;
        d2e_flush = 1'b0;
        e2m_en    = 1'b1;
        e2m_flush = 1'b0;
        m2w_en    = 1'b1;
        m2w_flush = 1'b0;
        if (d_busy) begin
            pc_en     = 1'b0;
            f2d_en    = 1'b0;
            d2e_en    = 1'b0;
            e2m_en    = 1'b0;
            m2w_flush = 1'b1;
        end else if (mdu_stall) begin
            pc_en     = 1'b0;
            f2d_en    = 1'b0;
            d2e_en    = 1'b0;
            e2m_flush = 1'b1;
        end else if (redir_wait) begin
            pc_en     = !i_busy;
            f2d_flush = 1'b1;
        end else if (ex_redirect) begin
            pc_en     = !i_busy;
            f2d_flush = 1'b1;
            d2e_flush = 1'b1;
        end else if (load_use) begin
            pc_en     = 1'b0;
            f2d_en    = 1'b0;
            d2e_flush = 1'b1;
        end else if (i_busy) begin
            pc_en     = 1'b0;
            f2d_flush = 1'b1;
        end
        // Wrong-path fetch data is discarded for as long as the redirect waits.
        if (redir_wait) begin
            f2d_flush = 1'b1;
        end
    end

    always_comb begin
        mdu_d = mdu_q;
        cnt_d = cnt_q;
        unique case (mdu_q)
            M_IDLE: begin
                if (ex_mdu_start && !d_busy) begin
                    mdu_d = M_BUSY;
                    cnt_d = CNT_INIT;
                end
            end
            M_BUSY: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else if (!d_busy) begin
                    mdu_d = M_IDLE;
                end else begin
                    mdu_d = M_DONE;
                end
            end
            M_DONE: begin
                if (!d_busy) begin
                    mdu_d = M_IDLE;
                end
            end
            default: begin
                mdu_d = M_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        redir_d = redir_q;
        unique case (redir_q)
            R_IDLE: begin
                if (redir_accept && i_busy) begin
                    redir_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (!i_busy && !d_busy) begin
                    redir_d = R_IDLE;
                end
            end
            default: redir_d = R_IDLE;
        endcase
    end

    assign mdu_busy         = (mdu_q == M_BUSY);
    assign redirect_pending = redir_wait;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Both counters saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redir_accept && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_count  = flush_cnt_q;
`endif

endmodule
